// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative shift-add multiplier:
//   - state_t : controller state encoding (IDLE, RUN, FIN), 2 bits
//   - clog2   : ceiling log2, used to size the step counter
// ---------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Ceiling log2 of value; clog2(1) = 0, clog2(9) = 4.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier, responder end of the start/done multiply
// handshake. One operand pair is captured per accepted start; the 2*BW-bit
// product appears BW+1 edges later together with a one-cycle done pulse.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   request, sampled only while idle
//   a       in   [BW-1:0]   multiplicand, valid with start
//   b       in   [BW-1:0]   multiplier, valid with start
//   product out  [2*BW-1:0] registered result, held between done pulses
//   done    out  one-cycle completion pulse
//   busy    out  high from the capture edge until the done edge
// ---------------------------------------------------------------------------
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int BW     = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BW-1:0]   a,
  input  logic [BW-1:0]   b,
  output logic [2*BW-1:0] product,
  output logic            done,
  output logic            busy
);

  localparam int PW = 2 * BW;
  localparam int CW = clog2(BW + 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PW-1:0]   mcand_r;     // multiplicand, pre-shifted by the step count
  logic [BW-1:0]   mplier_r;    // multiplier, consumed LSB first
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   count_r;
  logic            sign_r;
  logic [PW-1:0]   product_r;
  logic            done_r;
  logic            busy_r;

  logic [BW-1:0]   a_mag_s;
  logic [BW-1:0]   b_mag_s;
  logic            sign_in_s;
  logic [PW-1:0]   acc_step_s;
  logic            last_step_s;

  // Operand magnitudes. -2^(BW-1) negates to itself, which read as an
  // unsigned BW-bit value is exactly 2^(BW-1), so no extra bit is needed.
  always_comb begin
    a_mag_s   = a;
    b_mag_s   = b;
    sign_in_s = 1'b0;
    if (SIGNED) begin
      sign_in_s = a[BW-1] ^ b[BW-1];
      if (a[BW-1]) begin
        a_mag_s = ~a + BW'(1);
      end else begin
        a_mag_s = a;
      end
      if (b[BW-1]) begin
        b_mag_s = ~b + BW'(1);
      end else begin
        b_mag_s = b;
      end
    end else begin
      sign_in_s = 1'b0;
    end
  end

  // One shift-add step: accumulate the shifted multiplicand when the
  // current multiplier bit is set.
  always_comb begin
    acc_step_s  = acc_r;
    last_step_s = (count_r == CW'(BW - 1));
    if (mplier_r[0]) begin
      acc_step_s = acc_r + mcand_r;
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      mcand_r   <= {PW{1'b0}};
      mplier_r  <= {BW{1'b0}};
      acc_r     <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      sign_r    <= 1'b0;
      product_r <= {PW{1'b0}};
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= {{BW{1'b0}}, a_mag_s};
            mplier_r <= b_mag_s;
            acc_r    <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            sign_r   <= sign_in_s;
            busy_r   <= 1'b1;
          end
        end
        RUN: begin
          acc_r    <= acc_step_s;
          mcand_r  <= {mcand_r[PW-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[BW-1:1]};
          count_r  <= count_r + CW'(1);
        end
        FIN: begin
          if (SIGNED && sign_r) begin
            product_r <= ~acc_r + PW'(1);
          end else begin
            product_r <= acc_r;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_r;
  assign done    = done_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Scoreboard bench for seq_multiplier: one unsigned and one signed instance
// (BW=8). Stimulus pushes the reference product into a per-instance queue;
// a negedge monitor pops and compares whenever done is high.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        u_start, s_start;
  logic [7:0]  u_a, u_b, s_a, s_b;
  logic [15:0] u_product, s_product;
  logic        u_done, s_done, u_busy, s_busy;

  logic [15:0] exp_u[$];
  logic [15:0] exp_s[$];
  int          checks = 0;
  int          passes = 0;
  int          u_done_cnt = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.BW(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(u_start), .a(u_a), .b(u_b),
    .product(u_product), .done(u_done), .busy(u_busy)
  );

  seq_multiplier #(.BW(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
    .product(s_product), .done(s_done), .busy(s_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product: plain integer arithmetic truncated to 16 bits.
  function automatic logic [15:0] ref_prod(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    int p;
    if (sgn) p = int'($signed(a)) * int'($signed(b));
    else     p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  function automatic logic dn(input bit sgn);
    return sgn ? s_done : u_done;
  endfunction

  function automatic logic bz(input bit sgn);
    return sgn ? s_busy : u_busy;
  endfunction

  task automatic set_in(input bit sgn, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (sgn) begin
      s_start = st; s_a = a; s_b = b;
    end else begin
      u_start = st; u_a = a; u_b = b;
    end
  endtask

  // Issue one multiply (called #1 after a posedge). start is held for
  // 'hold' edges; operands are scrambled after capture. With chain=1 the
  // task returns in the done cycle so the caller can start immediately.
  task automatic mul(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                     input int hold, input bit chain, output logic [15:0] prod);
    int lat;
    int busy_cyc;
    set_in(sgn, 1'b1, a, b);
    if (sgn) exp_s.push_back(ref_prod(1'b1, a, b));
    else     exp_u.push_back(ref_prod(1'b0, a, b));
    @(posedge clk); #1;
    lat = 0;
    busy_cyc = 0;
    while (!dn(sgn) && lat < 40) begin
      if (bz(sgn)) busy_cyc++;
      set_in(sgn, (lat + 1 < hold), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      lat++;
    end
    set_in(sgn, 1'b0, 8'($urandom), 8'($urandom));
    check("latency", lat, 9);
    check("busy_cycles", busy_cyc, 9);
    check("busy_in_done_cycle", bz(sgn), 0);
    prod = sgn ? s_product : u_product;
    if (!chain) begin
      @(posedge clk); #1;
      check("done_single_pulse", dn(sgn), 0);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (u_done) begin
      u_done_cnt++;
      if (exp_u.size() == 0) check("unexpected_done_u", 1, 0);
      else check("product_u", u_product, exp_u.pop_front());
    end
  end

  always @(negedge clk) begin
    if (s_done) begin
      if (exp_s.size() == 0) check("unexpected_done_s", 1, 0);
      else check("product_s", s_product, exp_s.pop_front());
    end
  end

  initial begin
    logic [15:0] p;
    logic [7:0]  xv[4];
    logic [7:0]  wv[4];
    int          sum, exp_sum, n0;

    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'd0, 8'd0);
    set_in(1'b1, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_product_u", u_product, 0);
    check("reset_done_u", u_done, 0);
    check("reset_busy_u", u_busy, 0);
    check("reset_product_s", s_product, 0);
    check("reset_busy_s", s_busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed unsigned cases
    mul(1'b0, 8'd13, 8'd11, 1, 1'b0, p);  check("u_13x11", p, 143);
    mul(1'b0, 8'd255, 8'd255, 1, 1'b0, p); check("u_255x255", p, 65025);
    repeat (5) @(posedge clk);
    #1;
    check("u_product_hold", u_product, 65025);
    mul(1'b0, 8'd0, 8'd200, 1, 1'b0, p);   check("u_0x200", p, 0);
    mul(1'b0, 8'd1, 8'd255, 1, 1'b0, p);   check("u_1x255", p, 255);

    // Directed signed cases
    mul(1'b1, 8'h80, 8'h80, 1, 1'b0, p);   check("s_m128xm128", p, 16'h4000);
    mul(1'b1, 8'h80, 8'd127, 1, 1'b0, p);  check("s_m128x127", p, 16'hC080);
    mul(1'b1, 8'hFF, 8'd1, 1, 1'b0, p);    check("s_m1x1", p, 16'hFFFF);
    mul(1'b1, 8'd7, 8'hFD, 1, 1'b0, p);    check("s_7xm3", p, 16'hFFEB);

    // start held 3 cycles: one product only (monitor flags extras)
    mul(1'b0, 8'd17, 8'd3, 3, 1'b0, p);
    repeat (15) @(posedge clk);
    #1;
    check("held_start_single", exp_u.size(), 0);

    // Start in the done cycle
    mul(1'b0, 8'd100, 8'd7, 1, 1'b1, p);
    mul(1'b0, 8'd9, 8'd12, 1, 1'b0, p);    check("b2b_second", p, 108);

    // Reset mid-run aborts
    set_in(1'b0, 1'b1, 8'd9, 8'd9);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 8'd0, 8'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_u.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_product", u_product, 0);
    check("abort_busy", u_busy, 0);
    check("abort_done", u_done, 0);
    n0 = u_done_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_done", u_done_cnt, n0);
    mul(1'b0, 8'd5, 8'd6, 1, 1'b0, p);     check("after_abort_5x6", p, 30);

    // Random, with random chaining and start hold
    for (int i = 0; i < 20; i++) begin
      mul(1'b0, 8'($urandom), 8'($urandom), int'($urandom_range(1, 3)), 1'($urandom), p);
      mul(1'b1, 8'($urandom), 8'($urandom), int'($urandom_range(1, 3)), 1'($urandom), p);
    end
    @(posedge clk); #1;

    // Dot-product sequencer usage
    xv = '{8'd1, 8'd2, 8'd3, 8'd4};
    wv = '{8'd5, 8'd6, 8'd7, 8'd8};
    sum = 0;
    exp_sum = 0;
    n0 = u_done_cnt;
    for (int i = 0; i < 4; i++) begin
      mul(1'b0, xv[i], wv[i], 1, 1'b0, p);
      sum += int'(p);
      exp_sum += int'(xv[i]) * int'(wv[i]);
    end
    check("dot_sum", sum, exp_sum);
    check("dot_sum_70", sum, 70);
    check("dot_mul_count", u_done_cnt - n0, 4);

    repeat (3) @(posedge clk);
    #1;
    check("queue_u_empty", exp_u.size(), 0);
    check("queue_s_empty", exp_s.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Iterative shift-add multiplier that serves the start/done multiply handshake used by the dot-product sequencer. It accepts one operand pair per start pulse and takes BW cycles to compute. It returns the 2*BW-bit product with a single-cycle done pulse. It is the responder end of the multiply interface, so one instance can be shared by MAC-style sequencers.

Parameters:
BW, 8, operand bit width (2..32)
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and product

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only while idle
a  input  BW  multiplicand, valid in the cycle start is high
b  input  BW  multiplier, valid in the cycle start is high
product  output  2*BW  result; registered, stable between done pulses
done  output  1  one-cycle pulse, product valid
busy  output  1  high from the capture edge until the done edge (not during the done cycle)

Behaviour:
- Reset: rst synchronous, active-high; clock clk. Reset values: state=IDLE, product=0, done=0, busy=0, internal registers cleared. Reset mid-operation aborts it: no done is produced and product keeps 0.
- States:
  - IDLE: start=1 at an edge captures a and b, clears the accumulator and count, sets busy=1, goes to RUN. In SIGNED mode the magnitudes |a| and |b| are captured and the sign is stored as sign(a) XOR sign(b).
  - RUN: one shift-add step per edge. If the multiplier LSB is 1, add the multiplicand shifted left by count to the accumulator. Then shift the multiplier right and increment count. After the BW-th step, go to FIN.
  - FIN: one edge. Load product with the accumulator, negated if SIGNED and the sign is set. Set done=1, busy=0, go to IDLE.
- Latency: start sampled at edge 0; done is high for exactly the cycle after edge BW+1. Latency is BW+1 in both modes.
- done is always a single-cycle pulse; it is never held high. Requesters detect completion on done alone.
- A start during the done-high cycle is accepted, since the block is in IDLE; done drops at that edge. Back-to-back throughput is one product per BW+2 cycles.
- Start while busy is ignored and not queued. Changes to a or b after capture have no effect.
- Width: accumulator is 2*BW bits with no overflow (max unsigned (2^BW-1)^2).
- SIGNED negation edge case: |-2^(BW-1)| = 2^(BW-1) is held in a BW-bit unsigned magnitude register and is correct. -2^(BW-1) * -2^(BW-1) = 2^(2BW-2) fits in 2*BW bits.
- product changes only at the FIN edge or on reset.

Decomposition:
- Shared package mul_pkg:
  - state encoding localparams IDLE, RUN, FIN (2-bit);
  - function clog2 for the count width, $clog2(BW+1).
- No sub-module is needed; datapath and FSM live in one module. A standalone sub-module is not justified.

Test Plan:
- Unsigned BW=8: a=13, b=11, one-cycle start -> done pulse exactly 9 cycles after the start edge, product=143, busy high for 9 cycles, done high for 1 cycle.
- Unsigned corners: 255*255 -> 65025; 0*200 -> 0; 1*255 -> 255. product holds its value until the next start.
- SIGNED=1 BW=8: -128*-128 -> 16384; -128*127 -> -16256 (0xC080); -1*1 -> 0xFFFF; 7*-3 -> -21.
- Protocol: start held high for 3 cycles during RUN -> one product only. Start issued in the done cycle -> second product correct with no lost request. Operands changed mid-run -> result unaffected.
- Reset at cycle 4 of RUN -> no done, product=0, busy=0. A following start with 5*6 -> 30.
- Integration: the dot-product sequencer drives this block with x=(1,2,3,4), w=(5,6,7,8) -> sum=70, each multiply seen exactly once.
